regfile_mp: RTL
===============

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter ZERO_REG, default 1; when 1, register 0 is hardwired to zero.
REQ-004 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have ports rd_addr_a / rd_addr_b, input, ADDR_W, read port A/B address.
REQ-007 SHALL have ports rd_data_a / rd_data_b, output, DATA_W, registered read data.
REQ-008 SHALL have ports rd_busy_a / rd_busy_b, output, 1, registered scoreboard bit for the addressed register.
REQ-009 SHALL have ports wr_en0 / wr_en1, input, 1, write-port enables.
REQ-010 SHALL have ports wr_addr0 / wr_addr1, input, ADDR_W, write addresses.
REQ-011 SHALL have ports wr_data0 / wr_data1, input, DATA_W, write data.
REQ-012 SHALL have port rsv_en, input, 1, reserve request: mark destination pending.
REQ-013 SHALL have port rsv_addr, input, ADDR_W, register to reserve.

Function
REQ-014 SHALL capture rd_data_x and rd_busy_x on every rising edge; read latency is exactly 1 cycle.
REQ-015 SHALL update the array on rising edge for each wr_enN=1 at wr_addrN.
REQ-016 SHALL, when both write ports target the same address in the same cycle, store wr_data1 (port 1 wins); port 0 write is dropped.
REQ-017 SHALL bypass write-first: a read addressing a register written in the same cycle returns the new data (port 1 data if both write it).
REQ-018 SHALL, when ZERO_REG=1, ignore writes and reserves to address 0; reads of address 0 return 0 with busy 0, including under bypass.
REQ-019 SHALL set busy[rsv_addr] on rising edge when rsv_en=1.
REQ-020 SHALL clear busy[wr_addrN] on rising edge for each accepted write.
REQ-021 SHALL, on same-cycle reserve and write to the same address, leave busy set (reserve wins); data is still written.
REQ-022 SHALL compute rd_busy_x from next-state busy (write-clear and reserve-set of the same cycle visible).
REQ-023 SHALL allow reserve of an already-busy register (busy stays 1, no error).
REQ-024 SHALL have no wrap-around or overflow behaviour; all addresses 0..2**ADDR_W-1 valid.

Reset
REQ-025 SHALL, on rst=1, asynchronously clear all registers, all busy bits, rd_data_a/b and rd_busy_a/b to 0.
REQ-026 SHALL ignore writes, reserves and reads while rst=1; first capture occurs on the first rising edge after deassertion.
REQ-027 SHALL, on reset mid-operation, discard all pending reservations (busy all 0 afterwards).

Structure
REQ-028 SHALL take DATA_W/ADDR_W defaults and reset-value constants from shared package regfile_pkg.
REQ-029 SHALL instantiate sub-module regfile_rd_port twice (A, B), each doing address select, write-first bypass, zero-reg masking, output registers.
REQ-030 SHALL keep the array, busy vector and write arbitration in regfile_mp.

Verification
REQ-031 SHALL cover: reset, then write 0xDEADBEEF to r5 via port 0; next cycle read A=r5 -> rd_data_a=0xDEADBEEF one cycle later.
REQ-032 SHALL cover: same-cycle wr_en0 r7=0x11, wr_en1 r7=0x22, rd_addr_b=r7 -> rd_data_b=0x22 next edge; later read r7=0x22.
REQ-033 SHALL cover: write 0xFFFF_FFFF to r0 with ZERO_REG=1, rsv r0 -> reads of r0 give 0, busy 0.
REQ-034 SHALL cover: rsv r3 -> rd_busy_a=1 for r3; write r3=0x5 -> busy 0 that same capture; simultaneous rsv+write r3 -> busy 1, data 0x5.
REQ-035 SHALL cover: load r1..r4 and reserve r2, assert rst between edges -> outputs 0 immediately; after release r1..r4 read 0, busy 0.
REQ-036 SHALL cover: both read ports on r9 while port 1 writes r9=0xA5A5 -> rd_data_a=rd_data_b=0xA5A5 next edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file slice.
package regfile_pkg;

    // Default geometry of the register file.
    localparam int unsigned DEF_DATA_W   = 32;
    localparam int unsigned DEF_ADDR_W   = 5;
    localparam bit          DEF_ZERO_REG = 1'b1;

    // Reset values for array words, read data and scoreboard bits.
    localparam logic RST_DATA_BIT = 1'b0;
    localparam logic RST_BUSY     = 1'b0;

    // Source selected by a read port for its next captured data word.
    typedef enum logic [1:0] {
        SRC_ARRAY = 2'd0,
        SRC_WR0   = 2'd1,
        SRC_WR1   = 2'd2,
        SRC_ZERO  = 2'd3
    } rd_src_e;

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: address select, write-first bypass,
// register-zero masking and the output registers.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter bit          ZERO_REG = DEF_ZERO_REG
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_W-1:0]    rd_addr,
    input  logic [DATA_W-1:0]    regs [2**ADDR_W],
    input  logic [2**ADDR_W-1:0] busy_nxt,
    input  logic                 wr_ok0,
    input  logic [ADDR_W-1:0]    wr_addr0,
    input  logic [DATA_W-1:0]    wr_data0,
    input  logic                 wr_ok1,
    input  logic [ADDR_W-1:0]    wr_addr1,
    input  logic [DATA_W-1:0]    wr_data1,
    output logic [DATA_W-1:0]    rd_data,
    output logic                 rd_busy
);

    rd_src_e             src;
    logic [DATA_W-1:0]   data_sel;
    logic                busy_sel;

    // Pick the data source; port 1 is checked first so it wins a bypass tie.
    always_comb begin
        src = SRC_ARRAY;
        if (ZERO_REG && rd_addr == '0) begin
            src = SRC_ZERO;
        end else if (wr_ok1 && wr_addr1 == rd_addr) begin
            src = SRC_WR1;
        end else if (wr_ok0 && wr_addr0 == rd_addr) begin
            src = SRC_WR0;
        end
    end

    // Form the next captured data and scoreboard bit from the selected source.
    always_comb begin
        data_sel = {DATA_W{RST_DATA_BIT}};
        busy_sel = busy_nxt[rd_addr];
        case (src)
            SRC_ARRAY: data_sel = regs[rd_addr];
            SRC_WR0:   data_sel = wr_data0;
            SRC_WR1:   data_sel = wr_data1;
            SRC_ZERO: begin
                data_sel = {DATA_W{RST_DATA_BIT}};
                busy_sel = RST_BUSY;
            end
            default:   data_sel = {DATA_W{RST_DATA_BIT}};
        endcase
    end

    // Output registers: one-cycle read latency, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= {DATA_W{RST_DATA_BIT}};
            rd_busy <= RST_BUSY;
        end else begin
            rd_data <= data_sel;
            rd_busy <= busy_sel;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Two-read / two-write register file with a per-register busy scoreboard.
// Owns the array, the busy vector and write-port arbitration.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter bit          ZERO_REG = DEF_ZERO_REG
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_busy_a,
    output logic              rd_busy_b,
    input  logic              wr_en0,
    input  logic              wr_en1,
    input  logic [ADDR_W-1:0] wr_addr0,
    input  logic [ADDR_W-1:0] wr_addr1,
    input  logic [DATA_W-1:0] wr_data0,
    input  logic [DATA_W-1:0] wr_data1,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr
);

    localparam int unsigned DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic              wr_ok0;
    logic              wr_ok1;
    logic              rsv_ok;

    // Accept/drop decisions: register 0 is immune when hardwired, and
    // port 0 yields to port 1 on an address collision.
    always_comb begin
        wr_ok1 = wr_en1 && !(ZERO_REG && wr_addr1 == '0);
        wr_ok0 = wr_en0 && !(ZERO_REG && wr_addr0 == '0)
                        && !(wr_ok1 && wr_addr1 == wr_addr0);
        rsv_ok = rsv_en && !(ZERO_REG && rsv_addr == '0);
    end

    // Next scoreboard: writes clear, then a reserve sets so it wins a tie.
    always_comb begin
        busy_nxt = busy;
        if (wr_ok0) begin
            busy_nxt[wr_addr0] = RST_BUSY;
        end
        if (wr_ok1) begin
            busy_nxt[wr_addr1] = RST_BUSY;
        end
        if (rsv_ok) begin
            busy_nxt[rsv_addr] = 1'b1;
        end
    end

    // Scoreboard register; reset discards every pending reservation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= {DEPTH{RST_BUSY}};
        end else begin
            busy <= busy_nxt;
        end
    end

    // Register array update for the accepted writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= {DATA_W{RST_DATA_BIT}};
            end
        end else begin
            if (wr_ok0) begin
                regs[wr_addr0] <= wr_data0;
            end
            if (wr_ok1) begin
                regs[wr_addr1] <= wr_data1;
            end
        end
    end

    regfile_rd_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_rd_a (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr_a),
        .regs     (regs),
        .busy_nxt (busy_nxt),
        .wr_ok0   (wr_ok0),
        .wr_addr0 (wr_addr0),
        .wr_data0 (wr_data0),
        .wr_ok1   (wr_ok1),
        .wr_addr1 (wr_addr1),
        .wr_data1 (wr_data1),
        .rd_data  (rd_data_a),
        .rd_busy  (rd_busy_a)
    );

    regfile_rd_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_rd_b (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr_b),
        .regs     (regs),
        .busy_nxt (busy_nxt),
        .wr_ok0   (wr_ok0),
        .wr_addr0 (wr_addr0),
        .wr_data0 (wr_data0),
        .wr_ok1   (wr_ok1),
        .wr_addr1 (wr_addr1),
        .wr_data1 (wr_data1),
        .rd_data  (rd_data_b),
        .rd_busy  (rd_busy_b)
    );

endmodule
